// File: rtl/btn_pkg.sv
// Shared types and default timing for the button event decoder.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_IDLE,
        ST_PRESS,
        ST_LONG
    } btn_state_t;

    localparam int unsigned BTN_LONG_DEF = 8;
    localparam int unsigned BTN_RPT_DEF  = 4;

endpackage

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/click/long/repeat events.
// The falling-edge pulse is named release_evt because 'release' is a reserved word.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = BTN_LONG_DEF,
    parameter int unsigned REPEAT_CYCLES = BTN_RPT_DEF,
    parameter int unsigned CNT_W         = $clog2(LONG_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic db,
    input  logic en,
    output logic press,
    output logic release_evt,
    output logic click,
    output logic long_press,
    output logic rpt,
    output logic held
);

    localparam logic [CNT_W:0] LONG_CMP = (CNT_W + 1)'(LONG_CYCLES);
    localparam logic [CNT_W:0] RPT_CMP  = (CNT_W + 1)'(REPEAT_CYCLES);

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so the compare against LONG_CYCLES can never alias.
    assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_WAIT_LOW;
            cnt         <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            click       <= 1'b0;
            long_press  <= 1'b0;
            rpt         <= 1'b0;
            held        <= 1'b0;
        end else begin
            press       <= 1'b0;
            release_evt <= 1'b0;
            click       <= 1'b0;
            long_press  <= 1'b0;
            rpt         <= 1'b0;

            if (!en) begin
                // Abort silently: no release for a hold cut short by en.
                state <= ST_WAIT_LOW;
                cnt   <= '0;
                held  <= 1'b0;
            end else begin
                unique case (state)
                    ST_WAIT_LOW: begin
                        held <= 1'b0;
                        if (!db) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (db) begin
                            state <= ST_PRESS;
                            press <= 1'b1;
                            cnt   <= CNT_W'(1);
                            held  <= 1'b1;
                        end else begin
                            held <= 1'b0;
                        end
                    end
                    ST_PRESS: begin
                        if (!db) begin
                            state       <= ST_IDLE;
                            release_evt <= 1'b1;
                            click       <= 1'b1;
                            cnt         <= '0;
                            held        <= 1'b0;
                        end else if (cnt_inc == LONG_CMP) begin
                            state      <= ST_LONG;
                            long_press <= 1'b1;
                            cnt        <= '0;
                            held       <= 1'b1;
                        end else begin
                            cnt  <= cnt_inc[CNT_W-1:0];
                            held <= 1'b1;
                        end
                    end
                    ST_LONG: begin
                        if (!db) begin
                            state       <= ST_IDLE;
                            release_evt <= 1'b1;
                            cnt         <= '0;
                            held        <= 1'b0;
                        end else if (cnt_inc == RPT_CMP) begin
                            rpt  <= 1'b1;
                            cnt  <= '0;
                            held <= 1'b1;
                        end else begin
                            cnt  <= cnt_inc[CNT_W-1:0];
                            held <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_WAIT_LOW;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed and random stimulus for btn_event_decoder against a hold-length reference model.
module tb_btn_event_decoder;

    localparam int LONG = 8;
    localparam int RPT  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic db;
    logic en;
    logic press, release_evt, click, long_press, rpt, held;

    int tests = 0;
    int fails = 0;

    // Reference model: armed = a low has been seen since reset/abort,
    // active = an accepted press is in progress, len = its high-sample count.
    bit         m_armed;
    bit         m_active;
    int         m_len;
    logic [5:0] m_exp;  // {press, release, click, long_press, rpt, held}

    btn_event_decoder #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .db         (db),
        .en         (en),
        .press      (press),
        .release_evt(release_evt),
        .click      (click),
        .long_press (long_press),
        .rpt        (rpt),
        .held       (held)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_armed  = 1'b0;
        m_active = 1'b0;
        m_len    = 0;
        m_exp    = '0;
    endtask

    task automatic m_sample(input logic d, input logic e);
        logic p, r, c, l, rp;
        p = 1'b0; r = 1'b0; c = 1'b0; l = 1'b0; rp = 1'b0;
        if (!e) begin
            m_armed  = 1'b0;
            m_active = 1'b0;
            m_len    = 0;
        end else if (!m_armed) begin
            if (!d) m_armed = 1'b1;
        end else if (!m_active) begin
            if (d) begin
                m_active = 1'b1;
                m_len    = 1;
                p        = 1'b1;
            end
        end else if (d) begin
            m_len = m_len + 1;
            if (m_len == LONG) l = 1'b1;
            else if (m_len > LONG && (m_len - LONG) % RPT == 0) rp = 1'b1;
        end else begin
            r        = 1'b1;
            c        = (m_len < LONG);
            m_active = 1'b0;
            m_len    = 0;
        end
        m_exp = {p, r, c, l, rp, m_active};
    endtask

    task automatic check(input string tag);
        logic [5:0] obs;
        obs   = {press, release_evt, click, long_press, rpt, held};
        tests = tests + 1;
        assert (obs === m_exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %b expected %b (press,rel,click,long,rpt,held)",
                   tag, obs, m_exp);
        end
    endtask

    task automatic step(input logic d, input logic e, input string tag);
        db = d;
        en = e;
        @(posedge clk);
        m_sample(d, e);
        #1;
        check(tag);
    endtask

    task automatic steps(input int n, input logic d, input logic e, input string tag);
        for (int i = 0; i < n; i++) step(d, e, tag);
    endtask

    initial begin
        rst_n = 1'b1;
        db    = 1'b1;
        en    = 1'b1;
        m_reset();
        #1 rst_n = 1'b0;
        #2;
        check("reset_async");
        @(posedge clk);
        #1;
        check("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: held through reset never presses; then a 3-sample hold
        steps(20, 1'b1, 1'b1, "s1_held_through_reset");
        steps(2, 1'b0, 1'b1, "s1_low");
        steps(3, 1'b1, 1'b1, "s1_short_hold");
        steps(2, 1'b0, 1'b1, "s1_fall");

        // 2: 7 samples -> click, no long
        steps(7, 1'b1, 1'b1, "s2_hold7");
        steps(2, 1'b0, 1'b1, "s2_fall");

        // 3: exactly 8 samples -> long, release without click
        steps(8, 1'b1, 1'b1, "s3_hold8");
        steps(2, 1'b0, 1'b1, "s3_fall");

        // 4: 20 samples -> long then repeats
        steps(20, 1'b1, 1'b1, "s4_hold20");
        steps(2, 1'b0, 1'b1, "s4_fall");

        // 1-sample glitch
        step(1'b1, 1'b1, "glitch_rise");
        steps(2, 1'b0, 1'b1, "glitch_fall");

        // 5: en drops mid-hold
        steps(4, 1'b1, 1'b1, "s5_hold");
        steps(5, 1'b1, 1'b0, "s5_en_low");
        steps(5, 1'b1, 1'b1, "s5_en_back_db_high");
        steps(3, 1'b0, 1'b1, "s5_db_low");
        steps(2, 1'b1, 1'b1, "s5_rise");
        // en low on the same sample as a rise
        step(1'b0, 1'b1, "en_rise_prep");
        step(1'b1, 1'b0, "en_low_on_rise");
        steps(2, 1'b0, 1'b1, "en_rise_recover");

        // 6: async reset during ST_LONG, mid-cycle
        steps(10, 1'b1, 1'b1, "s6_to_long");
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("s6_async_clear");
        #3 rst_n = 1'b1;
        steps(5, 1'b1, 1'b1, "s6_after_reset_high");
        step(1'b0, 1'b1, "s6_low");
        steps(3, 1'b1, 1'b1, "s6_press");
        step(1'b0, 1'b0, "s6_clear");

        // Random runs: flip db ~1/8 samples, occasional en drop
        for (int i = 0; i < 1500; i++) begin
            logic d, e;
            d = ($urandom_range(0, 7) == 0) ? ~db : db;
            e = ($urandom_range(0, 49) != 0);
            step(d, e, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
Consumes the clean, clock-synchronous level produced by the switch debouncer and turns it into one-cycle user-interface events: press, release, short click, long press and auto-repeat. It sits between the debouncer output and the control FSMs, so that no downstream block does its own edge detection or hold timing. The level output `held` is also provided for indicator LEDs.

Parameters:
LONG_CYCLES, 8, consecutive high samples, counting the rising sample as 1, at which long_press fires; legal range ≥ 2
REPEAT_CYCLES, 4, high samples between successive rpt pulses after long_press; legal range ≥ 1
CNT_W, $clog2(LONG_CYCLES+1), hold-counter width; must also satisfy 2**CNT_W > REPEAT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
db  in  1  debounced switch level, already synchronous to clk, 1 = pressed
en  in  1  event enable; 0 forces the FSM to ST_WAIT_LOW and suppresses all events
press  out  1  one-cycle pulse on an accepted rising level
release  out  1  one-cycle pulse on any falling level that ends an accepted press
click  out  1  one-cycle pulse, coincident with release, when the hold was shorter than LONG_CYCLES
long_press  out  1  one-cycle pulse at the LONG_CYCLES-th high sample
rpt  out  1  one-cycle pulse every REPEAT_CYCLES high samples after long_press
held  out  1  level, 1 while in ST_PRESS or ST_LONG

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - State ST_WAIT_LOW, counter 0.
  - A switch held through reset never produces press.
- All outputs are registered. An event decided on the sample at edge k is visible for exactly the cycle after edge k, which gives 1-cycle latency from the db change.
- States:
  - ST_WAIT_LOW: db=0 and en=1 → ST_IDLE. Otherwise stay. No events.
  - ST_IDLE: db=1 → ST_PRESS, press=1, cnt=1. Otherwise stay.
  - ST_PRESS, db=0 → ST_IDLE, release=1, click=1.
  - ST_PRESS, db=1, cnt+1 == LONG_CYCLES → ST_LONG, long_press=1, cnt=0.
  - ST_PRESS, db=1, otherwise → cnt+1.
  - ST_LONG, db=0 → ST_IDLE, release=1, click=0.
  - ST_LONG, db=1, cnt+1 == REPEAT_CYCLES → rpt=1, cnt=0.
  - ST_LONG, db=1, otherwise → cnt+1.
- en=0 overrides every state: next state ST_WAIT_LOW, cnt=0, no pulses.
  - This holds even if en falls while in ST_PRESS or ST_LONG: no release is emitted, and held drops the next cycle.
  - It also holds on the same cycle as a db rise.
- The counter never wraps. It is reloaded to 0 on a long_press or rpt decision and otherwise counts at most to LONG_CYCLES-1.
- A 1-sample-high db glitch, i.e. a rise followed immediately by a fall, gives press, then release+click on consecutive cycles.
- At most one of press/long_press/rpt/release is asserted in any cycle. click is only ever asserted together with release.
- Reset asserted mid-press: outputs clear immediately. After reset, the block waits for db=0 before any press can be accepted.

Decomposition:
- Shared package btn_pkg:
  - Enum btn_state_t {ST_WAIT_LOW, ST_IDLE, ST_PRESS, ST_LONG}, 2-bit logic base.
  - Default timing localparams BTN_LONG_DEF=8, BTN_RPT_DEF=4.
- No sub-module. A single FSM plus hold counter fits comfortably in one module.

Test Plan:
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4.
1. db=1 during reset and 20 cycles after, en=1 → no pulses, held=0. Then db=0 for 2 cycles, db=1 for 3 samples, db=0 → press one cycle after the rise; release+click one cycle after the fall; held high 3 cycles.
2. db high for exactly 7 samples → press then release+click; long_press never asserted.
3. db high for exactly 8 samples → long_press in the cycle after the 8th high sample; on the fall, release=1 and click=0.
4. db high for 20 samples → long_press after sample 8; rpt after samples 12, 16 and 20; then release only.
5. en dropped at sample 5 of a hold while db stays 1, en raised at sample 10, db falls at 15, rises at 18 → no release for the aborted hold; no events until the rise at 18, which produces press.
6. Async rst_n pulse mid-clock during ST_LONG → all outputs 0 without waiting for a clock edge; after release with db=1, no press until db has been sampled 0.
